// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: all handshake and data signals between the cache
// request channels, the arbiter and the external memory port.
//   slave  : the arbiter's view (takes cache requests and memory responses,
//            drives grants, read beats and the memory request)
//   master : the environment's view (caches plus external memory)
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 32
);
  logic                  ic_rd_req;
  logic [ADDR_WIDTH-1:0] ic_rd_addr;
  logic                  ic_rd_gnt;
  logic                  ic_rd_valid;
  logic                  ic_rd_last;

  logic                  dc_rd_req;
  logic [ADDR_WIDTH-1:0] dc_rd_addr;
  logic                  dc_rd_gnt;
  logic                  dc_rd_valid;
  logic                  dc_rd_last;

  logic [DATA_WIDTH-1:0] rd_data;

  logic                  dc_wr_req;
  logic [ADDR_WIDTH-1:0] dc_wr_addr;
  logic [DATA_WIDTH-1:0] dc_wr_data;
  logic                  dc_wr_gnt;
  logic                  dc_wr_next;

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ack;
  logic                  mem_rvalid;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  ic_rd_req, ic_rd_addr, dc_rd_req, dc_rd_addr,
    input  dc_wr_req, dc_wr_addr, dc_wr_data,
    input  mem_ack, mem_rvalid, mem_rdata,
    output ic_rd_gnt, ic_rd_valid, ic_rd_last,
    output dc_rd_gnt, dc_rd_valid, dc_rd_last, rd_data,
    output dc_wr_gnt, dc_wr_next,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output ic_rd_req, ic_rd_addr, dc_rd_req, dc_rd_addr,
    output dc_wr_req, dc_wr_addr, dc_wr_data,
    output mem_ack, mem_rvalid, mem_rdata,
    input  ic_rd_gnt, ic_rd_valid, ic_rd_last,
    input  dc_rd_gnt, dc_rd_valid, dc_rd_last, rd_data,
    input  dc_wr_gnt, dc_wr_next,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: serializes whole-line bursts from the i-cache read, d-cache
// read and d-cache write-back channels onto one external memory port.
// Fixed priority dc_wr > dc_rd > ic_rd; read beats are forwarded
// combinationally to the channel that owns the transaction.
//
// Ports:
//   clk_i  rising-edge clock
//   rst_i  synchronous active-high reset
//   bus    mem_arbiter_if.slave (cache channels + external memory port)
//
// Optional feature: define MEM_ARB_STARVE_GUARD_EN to add per-read-channel
// wait counters; a channel that has waited STARVE_LIMIT cycles wins in IDLE.
//
// state   | meaning
// IDLE    | arbitrate, capture winner address and type
// GRANT   | one-cycle gnt pulse to the winner
// RD_REQ  | read request on memory port, waiting for mem_ack
// RD_DATA | forwarding BURST_LEN read beats to the owner
// WR      | write beats, one per mem_ack
// DONE    | one dead cycle before re-arbitration
module mem_arbiter #(
  parameter int ADDR_WIDTH   = 26,
  parameter int DATA_WIDTH   = 32,
  parameter int BURST_LEN    = 4,
  parameter int STARVE_LIMIT = 16
) (
  input logic          clk_i,
  input logic          rst_i,
  mem_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(BURST_LEN);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  if (BURST_LEN < 2 || BURST_LEN > 16 || (BURST_LEN & (BURST_LEN - 1)) != 0 ||
      STARVE_LIMIT < 1) begin : g_param_check
    $error("mem_arbiter: BURST_LEN must be a power of two in 2..16, STARVE_LIMIT >= 1");
  end

  typedef enum logic [2:0] {IDLE, GRANT, RD_REQ, RD_DATA, WR, DONE} state_t;
  typedef enum logic [1:0] {OWN_IC = 2'd0, OWN_DC = 2'd1, OWN_WR = 2'd2} owner_t;

  state_t                state_q, state_d;
  owner_t                owner_q, owner_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic ic_gnt, dc_gnt, wr_gnt;
  logic ic_starved, dc_starved;

  assign ic_gnt = (state_q == GRANT) && (owner_q == OWN_IC);
  assign dc_gnt = (state_q == GRANT) && (owner_q == OWN_DC);
  assign wr_gnt = (state_q == GRANT) && (owner_q == OWN_WR);

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT);

  logic [WAIT_W-1:0] ic_wait_q, ic_wait_d, dc_wait_q, dc_wait_d;

  // Counters only clear on a grant; a starved channel that drops its
  // request keeps its count but cannot win without a live request.
  assign ic_starved = (ic_wait_q == WAIT_MAX);
  assign dc_starved = (dc_wait_q == WAIT_MAX);

  always_comb begin
    ic_wait_d = ic_wait_q;
    dc_wait_d = dc_wait_q;
    if (ic_gnt)                              ic_wait_d = '0;
    else if (bus.ic_rd_req && !ic_starved)   ic_wait_d = ic_wait_q + WAIT_W'(1);
    if (dc_gnt)                              dc_wait_d = '0;
    else if (bus.dc_rd_req && !dc_starved)   dc_wait_d = dc_wait_q + WAIT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ic_wait_q <= '0;
      dc_wait_q <= '0;
    end else begin
      ic_wait_q <= ic_wait_d;
      dc_wait_q <= dc_wait_d;
    end
  end
`else
  assign ic_starved = 1'b0;
  assign dc_starved = 1'b0;
`endif

  assign bus.ic_rd_gnt = ic_gnt;
  assign bus.dc_rd_gnt = dc_gnt;
  assign bus.dc_wr_gnt = wr_gnt;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = bus.dc_wr_data;

  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    addr_d          = addr_q;
    cnt_d           = cnt_q;
    bus.mem_req     = 1'b0;
    bus.mem_we      = 1'b0;
    bus.ic_rd_valid = 1'b0;
    bus.ic_rd_last  = 1'b0;
    bus.dc_rd_valid = 1'b0;
    bus.dc_rd_last  = 1'b0;
    bus.rd_data     = '0;
    bus.dc_wr_next  = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = GRANT;
        if (ic_starved && bus.ic_rd_req) begin
          owner_d = OWN_IC;
          addr_d  = bus.ic_rd_addr;
        end else if (dc_starved && bus.dc_rd_req) begin
          owner_d = OWN_DC;
          addr_d  = bus.dc_rd_addr;
        end else if (bus.dc_wr_req) begin
          owner_d = OWN_WR;
          addr_d  = bus.dc_wr_addr;
        end else if (bus.dc_rd_req) begin
          owner_d = OWN_DC;
          addr_d  = bus.dc_rd_addr;
        end else if (bus.ic_rd_req) begin
          owner_d = OWN_IC;
          addr_d  = bus.ic_rd_addr;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        cnt_d   = '0;
        state_d = (owner_q == OWN_WR) ? WR : RD_REQ;
      end
      RD_REQ: begin
        bus.mem_req = 1'b1;
        if (bus.mem_ack) begin
          cnt_d   = '0;
          state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        if (bus.mem_rvalid) begin
          bus.rd_data = bus.mem_rdata;
          if (owner_q == OWN_IC) begin
            bus.ic_rd_valid = 1'b1;
            bus.ic_rd_last  = (cnt_q == LAST_BEAT);
          end else begin
            bus.dc_rd_valid = 1'b1;
            bus.dc_rd_last  = (cnt_q == LAST_BEAT);
          end
          if (cnt_q == LAST_BEAT) state_d = DONE;
          else                    cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      WR: begin
        bus.mem_req = 1'b1;
        bus.mem_we  = 1'b1;
        if (bus.mem_ack) begin
          bus.dc_wr_next = 1'b1;
          if (cnt_q == LAST_BEAT) state_d = DONE;
          else                    cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= OWN_IC;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a small memory responder and cache drivers
// run inside a per-cycle task; inputs change after the falling edge and
// outputs are sampled 1 time unit later.
module tb_mem_arbiter;
  localparam int AW = 26;
  localparam int DW = 32;
  localparam int BL = 4;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

  mem_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL), .STARVE_LIMIT(16)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int          beats_left = 0;
  int          beat_idx   = 0;
  logic [31:0] rd_base    = '0;
  logic [15:0] wr_pat     = '1;
  int          wr_cyc     = 0;
  int          wr_beat    = 0;
  logic        wr_ack_given = 1'b0;
  logic        manual_mem = 1'b0;
  logic        man_rvalid = 1'b0;
  logic        hold_dc    = 1'b0;

  int n_ic_beats, n_dc_beats, n_ic_last, n_dc_last, n_next, n_wr_req_cyc;
  int n_ic_gnt, n_dc_gnt;
  int gnt_log[$];
  int ic_gnt_cyc, first_mreq_cyc, last_next_cyc, mreq_after_wr;
  logic [31:0] first_maddr;
  logic        first_mwe;
  int s;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic reset_counts();
    n_ic_beats = 0; n_dc_beats = 0; n_ic_last = 0; n_dc_last = 0;
    n_next = 0; n_wr_req_cyc = 0; n_ic_gnt = 0; n_dc_gnt = 0;
    gnt_log.delete();
    ic_gnt_cyc = -1; first_mreq_cyc = -1; last_next_cyc = -1; mreq_after_wr = -1;
    first_maddr = '0; first_mwe = 1'b0;
    wr_beat = 0; wr_cyc = 0;
  endtask

  task automatic cycle();
    @(negedge clk_i);
    cyc++;
    wr_ack_given   = 1'b0;
    bus.mem_ack    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    if (manual_mem) begin
      bus.mem_rvalid = man_rvalid;
      bus.mem_rdata  = 32'hEE;
      beats_left     = 0;
    end else if (rst_i) begin
      beats_left = 0;
    end else if (beats_left > 0) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = rd_base + 32'(beat_idx);
      beat_idx++;
      beats_left--;
    end else if (bus.mem_req && !bus.mem_we) begin
      bus.mem_ack = 1'b1;
      beats_left  = BL;
      beat_idx    = 0;
    end else if (bus.mem_req && bus.mem_we) begin
      bus.mem_ack  = wr_pat[wr_cyc % 16];
      wr_ack_given = wr_pat[wr_cyc % 16];
      wr_cyc++;
    end
    bus.dc_wr_data = 32'hD0 + 32'(wr_beat);
    #1;
    if (bus.ic_rd_gnt) begin
      gnt_log.push_back(0); ic_gnt_cyc = cyc; n_ic_gnt++; bus.ic_rd_req = 1'b0;
    end
    if (bus.dc_rd_gnt) begin
      gnt_log.push_back(1); n_dc_gnt++;
      if (!hold_dc) bus.dc_rd_req = 1'b0;
    end
    if (bus.dc_wr_gnt) begin
      gnt_log.push_back(2); bus.dc_wr_req = 1'b0;
    end
    if (bus.mem_req && first_mreq_cyc < 0) begin
      first_mreq_cyc = cyc; first_maddr = 32'(bus.mem_addr); first_mwe = bus.mem_we;
    end
    if (bus.mem_req && !bus.mem_we && mreq_after_wr < 0 && last_next_cyc >= 0)
      mreq_after_wr = cyc;
    if (bus.ic_rd_valid || bus.dc_rd_valid) begin
      check_val("rd_data", bus.rd_data, rd_base + 32'(beat_idx) - 32'd1);
      check_val("rd_excl", 32'(bus.ic_rd_valid & bus.dc_rd_valid), 32'd0);
      check_val("rd_last", 32'(bus.ic_rd_last | bus.dc_rd_last), 32'(beat_idx == BL));
    end
    n_ic_beats += int'(bus.ic_rd_valid);
    n_dc_beats += int'(bus.dc_rd_valid);
    n_ic_last  += int'(bus.ic_rd_last);
    n_dc_last  += int'(bus.dc_rd_last);
    if (bus.mem_req && bus.mem_we) begin
      n_wr_req_cyc++;
      check_val("wdata", bus.mem_wdata, 32'hD0 + 32'(wr_beat));
    end
    if (bus.dc_wr_next || wr_ack_given)
      check_val("wr_next", 32'(bus.dc_wr_next), 32'(wr_ack_given));
    if (bus.dc_wr_next) begin
      n_next++; wr_beat++; last_next_cyc = cyc;
    end
  endtask

  initial begin
    bus.ic_rd_req = 1'b0; bus.ic_rd_addr = '0;
    bus.dc_rd_req = 1'b0; bus.dc_rd_addr = '0;
    bus.dc_wr_req = 1'b0; bus.dc_wr_addr = '0; bus.dc_wr_data = '0;
    bus.mem_ack = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    reset_counts();

    // reset state
    repeat (3) cycle();
    check_val("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check_val("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check_val("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check_val("rst_gnts", 32'({bus.ic_rd_gnt, bus.dc_rd_gnt, bus.dc_wr_gnt}), 32'd0);
    check_val("rst_valids", 32'({bus.ic_rd_valid, bus.dc_rd_valid, bus.ic_rd_last, bus.dc_rd_last}), 32'd0);
    check_val("rst_next", 32'(bus.dc_wr_next), 32'd0);
    rst_i = 1'b0;
    repeat (2) cycle();

    // single i-cache read
    reset_counts();
    rd_base = 32'hA0;
    bus.ic_rd_addr = 26'h0000100;
    bus.ic_rd_req  = 1'b1;
    s = cyc;
    repeat (14) cycle();
    check_val("t1_gnt_cyc", 32'(ic_gnt_cyc - s), 32'd1);
    check_val("t1_mreq_cyc", 32'(first_mreq_cyc - s), 32'd2);
    check_val("t1_addr", first_maddr, 32'h100);
    check_val("t1_we", 32'(first_mwe), 32'd0);
    check_val("t1_ic_beats", 32'(n_ic_beats), 32'd4);
    check_val("t1_ic_last", 32'(n_ic_last), 32'd1);
    check_val("t1_dc_beats", 32'(n_dc_beats), 32'd0);

    // all three channels request together
    reset_counts();
    rd_base = 32'hB0;
    bus.dc_wr_addr = 26'h0000200; bus.dc_wr_req = 1'b1;
    bus.dc_rd_addr = 26'h0000300; bus.dc_rd_req = 1'b1;
    bus.ic_rd_addr = 26'h0000400; bus.ic_rd_req = 1'b1;
    repeat (40) cycle();
    check_val("t2_n_gnt", 32'(gnt_log.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      check_val("t2_order", 32'((i < gnt_log.size()) ? gnt_log[i] : -1), 32'(2 - i));
    check_val("t2_next", 32'(n_next), 32'd4);
    check_val("t2_wr_cycles", 32'(n_wr_req_cyc), 32'd4);
    check_val("t2_dc_beats", 32'(n_dc_beats), 32'd4);
    check_val("t2_ic_beats", 32'(n_ic_beats), 32'd4);
    check_val("t2_turnaround", 32'(mreq_after_wr - last_next_cyc), 32'd4);

    // gapped write acks; an i-cache request withdrawn before its grant
    reset_counts();
    wr_pat = 16'b0000_0000_0011_1001;
    bus.dc_wr_addr = 26'h0000500; bus.dc_wr_req = 1'b1;
    bus.ic_rd_addr = 26'h0000600; bus.ic_rd_req = 1'b1;
    repeat (2) cycle();
    bus.ic_rd_req = 1'b0;
    repeat (18) cycle();
    wr_pat = '1;
    check_val("t3_next", 32'(n_next), 32'd4);
    check_val("t3_wr_cycles", 32'(n_wr_req_cyc), 32'd6);
    check_val("t3_last_ack", 32'(last_next_cyc - first_mreq_cyc), 32'd5);
    check_val("t3_ic_unserved", 32'(n_ic_gnt), 32'd0);
    check_val("t3_n_gnt", 32'(gnt_log.size()), 32'd1);

    // reset in the middle of a read burst
    reset_counts();
    rd_base = 32'hC0;
    bus.ic_rd_addr = 26'h0000700; bus.ic_rd_req = 1'b1;
    for (int i = 0; i < 20 && n_ic_beats < 2; i++) cycle();
    check_val("t4_two_beats", 32'(n_ic_beats), 32'd2);
    rst_i = 1'b1;
    manual_mem = 1'b1; man_rvalid = 1'b1;
    cycle();
    check_val("t4_rst_valid", 32'({bus.ic_rd_valid, bus.dc_rd_valid, bus.ic_rd_last, bus.dc_rd_last}), 32'd0);
    check_val("t4_rst_req", 32'({bus.mem_req, bus.mem_we, bus.dc_wr_next}), 32'd0);
    check_val("t4_rst_data", bus.rd_data, 32'd0);
    check_val("t4_rst_addr", 32'(bus.mem_addr), 32'd0);
    rst_i = 1'b0;
    cycle();
    check_val("t4_post_valid", 32'({bus.ic_rd_valid, bus.dc_rd_valid}), 32'd0);
    check_val("t4_post_data", bus.rd_data, 32'd0);
    manual_mem = 1'b0; man_rvalid = 1'b0;
    reset_counts();
    rd_base = 32'hC8;
    bus.ic_rd_req = 1'b1;
    s = cyc;
    repeat (14) cycle();
    check_val("t4_idle_gnt", 32'(ic_gnt_cyc - s), 32'd1);
    check_val("t4_new_beats", 32'(n_ic_beats), 32'd4);

    // continuous d-cache reads against a waiting i-cache read
    reset_counts();
    rd_base = 32'hE0;
    hold_dc = 1'b1;
    bus.dc_rd_addr = 26'h0000800; bus.dc_rd_req = 1'b1;
    bus.ic_rd_addr = 26'h0000900; bus.ic_rd_req = 1'b1;
    s = cyc;
`ifdef MEM_ARB_STARVE_GUARD_EN
    for (int i = 0; i < 60 && ic_gnt_cyc < 0; i++) cycle();
    check_val("t5_starve_gnt", 32'(ic_gnt_cyc >= 0 && ic_gnt_cyc <= s + 25), 32'd1);
`else
    repeat (120) cycle();
    check_val("t5_no_ic_gnt", 32'(n_ic_gnt), 32'd0);
    check_val("t5_dc_served", 32'(n_dc_last >= 10), 32'd1);
`endif
    hold_dc = 1'b0;
    bus.dc_rd_req = 1'b0;
    bus.ic_rd_req = 1'b0;
    repeat (20) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shared-memory arbiter between the core's three cache memory request channels (instruction-cache line read, data-cache line read, data-cache line write-back) and the single external memory port. It sits directly downstream of the core's memory interfaces. It serializes whole-line burst transactions, applies fixed priority with an optional anti-starvation guard, and routes returning read beats to the originating cache.

## Interface
Parameters:
- ADDR_WIDTH, 26: byte address width.
- DATA_WIDTH, 32: beat width.
- BURST_LEN, 4: beats per line transaction; power of two, 2..16.
- STARVE_LIMIT, 16: wait-cycle threshold for the starvation guard.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- ic_rd_req  in  1  i-cache line read request; held until granted.
- ic_rd_addr  in  ADDR_WIDTH  line base address.
- ic_rd_gnt  out  1  one-cycle pulse: address captured.
- ic_rd_valid  out  1  read beat valid.
- ic_rd_last  out  1  final beat of line.
- dc_rd_req / dc_rd_addr / dc_rd_gnt / dc_rd_valid / dc_rd_last: same as the i-cache channel, for the d-cache.
- rd_data  out  DATA_WIDTH  beat data, shared by both read channels.
- dc_wr_req  in  1  d-cache write-back request; held until granted.
- dc_wr_addr  in  ADDR_WIDTH  line base address.
- dc_wr_data  in  DATA_WIDTH  current write beat, combinationally forwarded.
- dc_wr_gnt  out  1  one-cycle pulse: address captured.
- dc_wr_next  out  1  current beat accepted; cache advances to the next beat.
- mem_req  out  1  transaction/beat request.
- mem_we  out  1  1 = write.
- mem_addr  out  ADDR_WIDTH  registered line base address.
- mem_wdata  out  DATA_WIDTH  equals dc_wr_data.
- mem_ack  in  1  read: request accepted (once); write: beat accepted.
- mem_rvalid  in  1  read beat valid.
- mem_rdata  in  DATA_WIDTH  read beat data.

## Operation
States:
- IDLE
- GRANT
- RD_REQ
- RD_DATA
- WR
- DONE

Transitions:
- IDLE: if any request is present, select the winner and register its address and type, then go to GRANT. The default priority is dc_wr > dc_rd > ic_rd.
- GRANT: pulse the winner's gnt, then go to RD_REQ (read) or WR (write).
- RD_REQ: assert mem_req=1, mem_we=0. On mem_ack, clear the beat counter and go to RD_DATA.
- RD_DATA: on each mem_rvalid, drive rd_data=mem_rdata and assert the owner's valid. When beat count is BURST_LEN-1, also assert last and go to DONE. The other channel's valid stays 0.
- WR: assert mem_req=1, mem_we=1. Each mem_ack pulses dc_wr_next in the same cycle and increments the counter. On the BURST_LEN-th ack, go to DONE.
- DONE: one idle cycle, then go to IDLE. The arbiter is re-evaluated in IDLE.

Rules:
- The beat counter is $clog2(BURST_LEN) bits wide. It is compared against BURST_LEN-1, so wrap-around is never used.
- A request dropped after its gnt is ignored; the transaction completes.
- A request dropped before its gnt is simply not served.
- mem_rvalid outside RD_DATA is ignored.
- mem_ack in RD_DATA is ignored.

## Timing
- Reset: all outputs are 0 and the state is IDLE. Reset mid-transaction aborts it immediately, with no further valid or next beats. The external memory is reset by the same rst.
- Minimum read latency: req seen at cycle 0; gnt at cycle 1; mem_req at cycle 2. Beats follow the memory's rvalid with 0-cycle added latency (combinational forwarding).
- rd_data, valid and last are combinational from mem_rdata and mem_rvalid, qualified by registered state.
- Back-to-back transactions are separated by IDLE and DONE, so the minimum overhead is 4 cycles from the final beat to the next mem_req.
- Simultaneous requests are resolved by priority in the single IDLE cycle. Losers keep waiting.

## Configuration
- MEM_ARB_STARVE_GUARD_EN defined:
  - A per-read-channel wait counter (saturating at STARVE_LIMIT) increments each cycle that the channel's req=1 without a gnt, and clears on its gnt.
  - In IDLE, a channel whose counter has reached STARVE_LIMIT wins over all others. ic_rd beats dc_rd if both are starved.
- Undefined: pure fixed priority, and no counters are synthesized.

## Test plan
- Single ic read, BURST_LEN=4, addr 0x0000100, memory returns 0xA0..0xA3: ic_rd_gnt at cycle 1, mem_addr=0x0000100, mem_we=0, 4 ic_rd_valid beats with those values, ic_rd_last on 0xA3, dc_rd_valid always 0.
- dc_wr, dc_rd and ic_rd all asserted at cycle 0: service order is write, then dc read, then ic read. dc_wr_next pulses exactly 4 times, mem_wdata tracks dc_wr_data each beat.
- Write with mem_ack gapped (ack, 2 idle cycles, ack, ack, ack): dc_wr_next is coincident with each ack, and DONE is entered only after the 4th ack.
- Reset asserted during RD_DATA after 2 beats: the next cycle all outputs are 0 and the state is IDLE. Further mem_rvalid produces no ic or dc valid.
- With the guard enabled and STARVE_LIMIT=16, dc_rd requested continuously and ic_rd held: ic_rd is granted no later than the first IDLE after its counter reaches 16. With the guard disabled, ic_rd is never granted while dc_rd stays asserted.
